dff_pipe: RTL and testbench

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline.
- Adds per-stage valid tracking, clock-enable stall, synchronous flush, an occupancy count and complementary q/qb outputs.
- Used as a configurable delay line and retiming block between datapath units.
- With DEPTH=1 and WIDTH=1 it is a drop-in functional superset of the plain flop.

---
 rtl/dff_pkg.sv | 12 +
 rtl/dff_stage.sv | 38 +++
 rtl/dff_pipe.sv | 73 +++++++
 tb/tb_dff_pipe.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// Shared defaults and sizing helper for the dff_pipe register pipeline.
package dff_pkg;

  localparam int DFF_DEFAULT_WIDTH = 8;
  localparam int DFF_DEFAULT_DEPTH = 4;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: WIDTH-bit data register plus its valid bit.
module dff_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_vld,
  output logic [WIDTH-1:0] o_q,
  output logic             o_vld
);

  logic [WIDTH-1:0] r_data;
  logic             r_vld;

  // Clear beats advance; data shifts regardless of the incoming valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= RESET_VAL;
      r_vld  <= 1'b0;
    end else if (i_clr) begin
      r_data <= RESET_VAL;
      r_vld  <= 1'b0;
    end else if (i_en) begin
      r_data <= i_d;
      r_vld  <= i_vld;
    end
  end

  assign o_q   = r_data;
  assign o_vld = r_vld;

endmodule

// File: rtl/dff_pipe.sv
// WIDTH x DEPTH register pipeline with valid tracking, stall, flush,
// occupancy count and complementary outputs.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DFF_DEFAULT_WIDTH,
  parameter int               DEPTH     = DFF_DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          flush,
  input  logic [WIDTH-1:0]              d,
  input  logic                          d_valid,
  output logic [WIDTH-1:0]              q,
  output logic [WIDTH-1:0]              qb,
  output logic                          q_valid,
  output logic [DEPTH*WIDTH-1:0]        taps,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int OW = occ_width(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] w_data;
  logic [DEPTH-1:0]            w_vld;
  logic [OW-1:0]               r_occ;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] w_din;
    logic             w_vin;

    if (gi == 0) begin : g_head
      assign w_din = d;
      assign w_vin = d_valid;
    end else begin : g_tail
      assign w_din = w_data[gi-1];
      assign w_vin = w_vld[gi-1];
    end

    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .rst_n (reset),
      .i_en  (en),
      .i_clr (flush),
      .i_d   (w_din),
      .i_vld (w_vin),
      .o_q   (w_data[gi]),
      .o_vld (w_vld[gi])
    );
  end

  // Tracked incrementally: one word in at stage 0, one word out of the last stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (en) begin
      r_occ <= r_occ + OW'(d_valid) - OW'(w_vld[DEPTH-1]);
    end
  end

  assign q         = w_data[DEPTH-1];
  assign qb        = ~w_data[DEPTH-1];
  assign q_valid   = w_vld[DEPTH-1];
  assign taps      = w_data;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed self-checking bench for dff_pipe (8x4 and 1x1 configurations).
module tb_dff_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, flush, d_valid;
  logic [7:0]  d;
  logic [7:0]  q, qb;
  logic        q_valid;
  logic [31:0] taps;
  logic [2:0]  occupancy;

  logic        en1, d1, dv1;
  logic        q1, qb1, qv1, taps1;
  logic        occ1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
    .q(q), .qb(qb), .q_valid(q_valid), .taps(taps), .occupancy(occupancy)
  );

  dff_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) dut1 (
    .clk(clk), .reset(reset), .en(en1), .flush(1'b0), .d(d1), .d_valid(dv1),
    .q(q1), .qb(qb1), .q_valid(qv1), .taps(taps1), .occupancy(occ1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [7:0] dd, input logic dv);
    en = e; d = dd; d_valid = dv;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    en1 = 1'b0; d1 = 1'b0; dv1 = 1'b0;
    #12;
    check("rst_q", q, 8'h00);
    check("rst_qb", qb, 8'hFF);
    check("rst_qv", q_valid, 1'b0);
    check("rst_occ", occupancy, 3'd0);
    check("rst_taps", taps, 32'h0);
    @(negedge clk) reset = 1'b1;

    // Fill
    drive(1'b1, 8'h11, 1'b1); step(); check("fill_occ1", occupancy, 3'd1);
    drive(1'b1, 8'h22, 1'b1); step(); check("fill_occ2", occupancy, 3'd2);
    check("fill_qv_early", q_valid, 1'b0);
    drive(1'b1, 8'h33, 1'b1); step(); check("fill_occ3", occupancy, 3'd3);
    drive(1'b1, 8'h44, 1'b1); step(); check("fill_occ4", occupancy, 3'd4);
    check("fill_q", q, 8'h11);
    check("fill_qv", q_valid, 1'b1);
    check("fill_tap0", taps[7:0], 8'h44);
    check("fill_taps", taps, 32'h11223344);

    // Stall: inputs ignored while en=0
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h55, 1'b1); step();
      check("stall_q", q, 8'h11);
      check("stall_occ", occupancy, 3'd4);
    end

    // Drain with d_valid=0
    drive(1'b1, 8'h00, 1'b0); step();
    check("drain_q1", q, 8'h22); check("drain_occ1", occupancy, 3'd3);
    step();
    check("drain_q2", q, 8'h33); check("drain_occ2", occupancy, 3'd2);
    step();
    check("drain_q3", q, 8'h44); check("drain_occ3", occupancy, 3'd1);
    check("drain_qv3", q_valid, 1'b1);
    step();
    check("drain_q4", q, 8'h00); check("drain_occ4", occupancy, 3'd0);
    check("drain_qv4", q_valid, 1'b0);

    // Refill then flush with en=1 and a valid word on d
    drive(1'b1, 8'h01, 1'b1); step();
    drive(1'b1, 8'h02, 1'b1); step();
    drive(1'b1, 8'h03, 1'b1); step();
    drive(1'b1, 8'h04, 1'b1); step();
    check("refill_taps", taps, 32'h01020304);
    flush = 1'b1; drive(1'b1, 8'hAA, 1'b1); step();
    flush = 1'b0;
    check("flush_taps", taps, 32'h0);
    check("flush_qv", q_valid, 1'b0);
    check("flush_occ", occupancy, 3'd0);
    check("flush_qb", qb, 8'hFF);
    drive(1'b0, 8'h00, 1'b0); step();
    check("flush_drop_taps", taps, 32'h0);

    // Async reset mid-stream with occupancy 3
    drive(1'b1, 8'hA1, 1'b1); step();
    drive(1'b1, 8'hA2, 1'b1); step();
    drive(1'b1, 8'hA3, 1'b1); step();
    check("pre_rst_occ", occupancy, 3'd3);
    check("pre_rst_taps", taps, 32'h00A1A2A3);
    drive(1'b0, 8'h00, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("arst_taps", taps, 32'h0);
    check("arst_occ", occupancy, 3'd0);
    check("arst_q", q, 8'h00);
    @(negedge clk) reset = 1'b1;
    drive(1'b1, 8'h5A, 1'b1); step();
    check("post_rst_occ1", occupancy, 3'd1);
    drive(1'b1, 8'h00, 1'b0); step(); step();
    check("post_rst_lat3_qv", q_valid, 1'b0);
    check("post_rst_lat3_q", q, 8'h00);
    step();
    check("post_rst_lat4_q", q, 8'h5A);
    check("post_rst_lat4_qv", q_valid, 1'b1);
    check("post_rst_lat4_occ", occupancy, 3'd1);

    // DEPTH=1, WIDTH=1
    check("d1_init_q", q1, 1'b0);
    check("d1_init_qb", qb1, 1'b1);
    en1 = 1'b1; d1 = 1'b1; dv1 = 1'b1; step();
    check("d1_q", q1, 1'b1);
    check("d1_qb", qb1, 1'b0);
    check("d1_qv", qv1, 1'b1);
    check("d1_occ", occ1, 1'b1);
    check("d1_taps", taps1, 1'b1);
    d1 = 1'b0; dv1 = 1'b0; step();
    check("d1_q2", q1, 1'b0);
    check("d1_qv2", qv1, 1'b0);
    check("d1_occ2", occ1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
